// File: rtl/icache_port_arb.sv
// icache_port_arb: shares one icache request port between fetch and a secondary
// requester, routing responses in issue order. Optional round-robin: ICACHE_ARB_RR_EN.
module icache_port_arb #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_req_valid,
    output logic            f_req_ready,
    input  logic [XLEN-1:0] f_req_addr,
    input  logic            p_req_valid,
    output logic            p_req_ready,
    input  logic [XLEN-1:0] p_req_addr,
    output logic            mem_addr_valid,
    input  logic            mem_addr_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_data_valid,
    input  logic [31:0]     mem_data,
    output logic            mem_data_ready,
    output logic            f_rsp_valid,
    output logic [31:0]     f_rsp_data,
    input  logic            f_rsp_ready,
    output logic            p_rsp_valid,
    output logic [31:0]     p_rsp_data,
    input  logic            p_rsp_ready,
    input  logic            squash_valid,
    output logic            proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic owner;
        logic killed;
    } tag_t;

    tag_t             tags [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    tag_t             head;
    logic             empty;
    logic             f_cand;
    logic             p_cand;
    logic             conflict;
    logic             grant_p;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] live;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign head     = tags[rd_idx];
    assign empty    = (count == '0);
    assign f_cand   = f_req_valid && !squash_valid;
    assign p_cand   = p_req_valid;
    assign conflict = f_cand && p_cand;

`ifdef ICACHE_ARB_RR_EN
    logic last_p;

    assign grant_p = p_cand && (!f_cand || !last_p);

    // remember who won the last contested handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_p <= 1'b1;
        end else if (push && conflict) begin
            last_p <= grant_p;
        end
    end
`else
    assign grant_p = p_cand && !f_cand;
`endif

    assign mem_addr_valid = !rst && (count < FULL) && mem_addr_ready
                          && (f_cand || p_cand);
    assign mem_addr       = grant_p ? p_req_addr : f_req_addr;
    assign f_req_ready    = mem_addr_valid && !grant_p;
    assign p_req_ready    = mem_addr_valid && grant_p;
    assign push           = mem_addr_valid && mem_addr_ready;

    assign f_rsp_data = mem_data;
    assign p_rsp_data = mem_data;

    // steer the head response to its owner, or drop it
    always_comb begin
        f_rsp_valid    = 1'b0;
        p_rsp_valid    = 1'b0;
        mem_data_ready = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                empty: begin
                    mem_data_ready = 1'b1;
                end
                (!empty && head.killed): begin
                    mem_data_ready = 1'b1;
                end
                (!empty && !head.killed && !head.owner): begin
                    f_rsp_valid    = mem_data_valid && !squash_valid;
                    mem_data_ready = f_rsp_ready || squash_valid;
                end
                (!empty && !head.killed && head.owner): begin
                    p_rsp_valid    = mem_data_valid;
                    mem_data_ready = p_rsp_ready;
                end
                default: begin
                    mem_data_ready = 1'b0;
                end
            endcase
        end
    end

    assign pop = mem_data_valid && mem_data_ready && !empty;

    // mark which slots hold outstanding requests
    always_comb begin
        logic [AW:0] diff;
        live = '0;
        diff = '0;
        for (int i = 0; i < DEPTH; i++) begin
            diff    = (AW+1)'(i) - rd_ptr;
            live[i] = ({1'b0, diff[AW-1:0]} < count);
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // write new tags and kill fetch-owned ones on squash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_idx == AW'(i)) begin
                    tags[i] <= tag_t'{owner: grant_p, killed: 1'b0};
                end else if (squash_valid && live[i] && !tags[i].owner) begin
                    tags[i].killed <= 1'b1;
                end
            end
        end
    end

    // sticky flag for a response that nothing asked for
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (mem_data_valid && empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_port_arb.sv
// tb_icache_port_arb: directed and randomized checks of icache_port_arb
// against a queue-based model of the outstanding request list.
module tb_icache_port_arb;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            f_req_valid = 1'b0;
    logic            f_req_ready;
    logic [XLEN-1:0] f_req_addr = '0;
    logic            p_req_valid = 1'b0;
    logic            p_req_ready;
    logic [XLEN-1:0] p_req_addr = '0;
    logic            mem_addr_valid;
    logic            mem_addr_ready = 1'b0;
    logic [XLEN-1:0] mem_addr;
    logic            mem_data_valid = 1'b0;
    logic [31:0]     mem_data = '0;
    logic            mem_data_ready;
    logic            f_rsp_valid;
    logic [31:0]     f_rsp_data;
    logic            f_rsp_ready = 1'b0;
    logic            p_rsp_valid;
    logic [31:0]     p_rsp_data;
    logic            p_rsp_ready = 1'b0;
    logic            squash_valid = 1'b0;
    logic            proto_err;

    always #5 clk = ~clk;

    icache_port_arb #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready),
        .f_req_addr(f_req_addr),
        .p_req_valid(p_req_valid), .p_req_ready(p_req_ready),
        .p_req_addr(p_req_addr),
        .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
        .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .mem_data_ready(mem_data_ready),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
        .f_rsp_ready(f_rsp_ready),
        .p_rsp_valid(p_rsp_valid), .p_rsp_data(p_rsp_data),
        .p_rsp_ready(p_rsp_ready),
        .squash_valid(squash_valid), .proto_err(proto_err)
    );

    typedef struct {
        bit owner;
        bit killed;
    } ent_t;

    ent_t        q[$];
    bit          last_win_p;
    bit          perr;
    int          total = 0;
    int          passed = 0;
    logic [31:0] got_f[$];
    logic [31:0] got_p[$];
    logic        obs_f_rdy;
    logic        obs_p_rdy;
    logic        obs_mdr;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_in(bit fv, logic [31:0] fa, bit pv, logic [31:0] pa,
                          bit mar, bit mdv, logic [31:0] md,
                          bit frr, bit prr, bit sq);
        f_req_valid    = fv;
        f_req_addr     = fa;
        p_req_valid    = pv;
        p_req_addr     = pa;
        mem_addr_ready = mar;
        mem_data_valid = mdv;
        mem_data       = md;
        f_rsp_ready    = frr;
        p_rsp_ready    = prr;
        squash_valid   = sq;
    endtask

    task automatic cyc();
        bit fc, pc, allow, gp, mav, frv, prv, mdr, empty;
        @(negedge clk);
        fc    = f_req_valid && !squash_valid;
        pc    = p_req_valid;
        allow = (q.size() < DEPTH) && mem_addr_ready;
        if (!fc) gp = pc;
        else if (!pc) gp = 1'b0;
`ifdef ICACHE_ARB_RR_EN
        else gp = !last_win_p;
`else
        else gp = 1'b0;
`endif
        mav   = allow && (fc || pc);
        empty = (q.size() == 0);
        frv = 1'b0;
        prv = 1'b0;
        mdr = 1'b0;
        if (empty) mdr = 1'b1;
        else if (q[0].killed) mdr = 1'b1;
        else if (!q[0].owner) begin
            frv = mem_data_valid && !squash_valid;
            mdr = f_rsp_ready || squash_valid;
        end else begin
            prv = mem_data_valid;
            mdr = p_rsp_ready;
        end
        chk("mem_addr_valid", mem_addr_valid, mav);
        if (mav) chk("mem_addr", mem_addr, gp ? p_req_addr : f_req_addr);
        chk("f_req_ready", f_req_ready, mav && !gp);
        chk("p_req_ready", p_req_ready, mav && gp);
        chk("f_rsp_valid", f_rsp_valid, frv);
        chk("p_rsp_valid", p_rsp_valid, prv);
        chk("mem_data_ready", mem_data_ready, mdr);
        if (frv) chk("f_rsp_data", f_rsp_data, mem_data);
        if (prv) chk("p_rsp_data", p_rsp_data, mem_data);
        chk("proto_err", proto_err, perr);
        chk("count", dut.count, q.size());
        obs_f_rdy = f_req_ready;
        obs_p_rdy = p_req_ready;
        obs_mdr   = mem_data_ready;
        if (f_rsp_valid && f_rsp_ready) got_f.push_back(f_rsp_data);
        if (p_rsp_valid && p_rsp_ready) got_p.push_back(p_rsp_data);
        @(posedge clk);
        if (squash_valid)
            foreach (q[i]) if (!q[i].owner) q[i].killed = 1'b1;
        if (mem_data_valid && mdr && !empty) void'(q.pop_front());
        if (mav) begin
            if (fc && pc) last_win_p = gp;
            q.push_back('{owner: gp, killed: 1'b0});
        end
        if (empty && mem_data_valid) perr = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 32'h1000, 1, 32'h2000, 1, 1, 32'h0, 1, 1, 0);
        rst = 1'b1;
        q.delete();
        last_win_p = 1'b1;
        perr = 1'b0;
        @(negedge clk);
        chk("rst_mem_addr_valid", mem_addr_valid, 0);
        chk("rst_f_req_ready", f_req_ready, 0);
        chk("rst_p_req_ready", p_req_ready, 0);
        chk("rst_f_rsp_valid", f_rsp_valid, 0);
        chk("rst_p_rsp_valid", p_rsp_valid, 0);
        chk("rst_mem_data_ready", mem_data_ready, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_count", dut.count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, 0, 1, q.size() > 0, 32'hC0DE_0000 + i, 1, 1, 0);
            cyc();
        end
    endtask

    initial begin
        logic [3:0] exp_pat;
        do_reset();

        // in-order fetch with one-cycle cache latency
        got_f.delete();
        set_in(1, 32'h8000_0000, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc();
        set_in(1, 32'h8000_0004, 0, 0, 1, 1, 32'hAAAA_0000, 1, 0, 0);
        cyc();
        chk("t1_count_peak", dut.count, 1);
        set_in(0, 0, 0, 0, 1, 1, 32'hAAAA_0004, 1, 0, 0);
        cyc();
        chk("t1_count_end", dut.count, 0);
        chk("t1_nrsp", got_f.size(), 2);
        if (got_f.size() == 2) begin
            chk("t1_word0", got_f[0], 32'hAAAA_0000);
            chk("t1_word1", got_f[1], 32'hAAAA_0004);
        end

        // full FIFO blocks a third request until a slot frees
        set_in(1, 32'h8000_0100, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc();
        set_in(1, 32'h8000_0104, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc();
        set_in(1, 32'h8000_0108, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc();
        chk("t2_full_block", obs_f_rdy, 0);
        chk("t2_full_count", dut.count, 2);
        set_in(1, 32'h8000_0108, 0, 0, 1, 1, 32'h1111_0001, 1, 0, 0);
        cyc();
        chk("t2_pop_no_issue", obs_f_rdy, 0);
        set_in(1, 32'h8000_0108, 0, 0, 1, 1, 32'h1111_0002, 1, 0, 0);
        cyc();
        chk("t2_push_pop", obs_f_rdy, 1);
        chk("t2_push_pop_count", dut.count, 1);
        drain();

        // squash kills both outstanding fetches
        got_f.delete();
        set_in(1, 32'h8000_0200, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc();
        set_in(1, 32'h8000_0204, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc();
        set_in(1, 32'h8000_0208, 0, 0, 1, 0, 0, 1, 0, 1);
        cyc();
        chk("t3_squash_block", obs_f_rdy, 0);
        set_in(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cyc();
        chk("t3_drop0", obs_mdr, 1);
        set_in(0, 0, 0, 0, 1, 1, 32'h1234_5678, 0, 0, 0);
        cyc();
        chk("t3_drop1", obs_mdr, 1);
        chk("t3_count", dut.count, 0);
        chk("t3_nrsp", got_f.size(), 0);

        // mixed owners: only the secondary survives a squash
        got_f.delete();
        got_p.delete();
        set_in(1, 32'h8000_0300, 0, 0, 1, 0, 0, 1, 1, 0);
        cyc();
        set_in(0, 0, 1, 32'h4000_0000, 1, 0, 0, 1, 1, 0);
        cyc();
        set_in(0, 0, 0, 0, 1, 0, 0, 1, 1, 1);
        cyc();
        set_in(0, 0, 0, 0, 1, 1, 32'hAAAA_0001, 1, 1, 0);
        cyc();
        set_in(0, 0, 0, 0, 1, 1, 32'h5555_0002, 1, 1, 0);
        cyc();
        chk("t4_nf", got_f.size(), 0);
        chk("t4_np", got_p.size(), 1);
        if (got_p.size() == 1) chk("t4_pword", got_p[0], 32'h5555_0002);

        // conflict grant sequence from reset
        do_reset();
`ifdef ICACHE_ARB_RR_EN
        exp_pat = 4'b1010;
`else
        exp_pat = 4'b0000;
`endif
        for (int k = 0; k < 4; k++) begin
            set_in(1, 32'h8000_0400 + 4 * k, 1, 32'h4000_0400 + 4 * k,
                   1, q.size() > 0, 32'hBEEF_0000 + k, 1, 1, 0);
            cyc();
            chk("t5_grant_p", obs_p_rdy, exp_pat[k]);
            chk("t5_grant_any", obs_f_rdy | obs_p_rdy, 1);
        end
        drain();

        // stray response with nothing outstanding
        set_in(0, 0, 0, 0, 1, 1, 32'hBAD0_0000, 1, 1, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            cyc();
            chk("t6_sticky", proto_err, 1);
        end

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 1), $urandom,
                   $urandom_range(0, 1), $urandom,
                   $urandom_range(0, 3) != 0,
                   (q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7) == 0);
            cyc();
        end

        do_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
